cpu_control_unit: RTL and testbench
===================================

// Module: cpu_control_unit
//
// PURPOSE
//   Sequencer/decoder for the basic 9-bit-instruction CPU datapath.
//   Tracks the instruction step T0..T3 in an internal 2-bit counter.
//   Decodes IR = [III YYY XXX] = [opcode, Rx (dest), Ry (source)] into
//   one-hot register-file enables, bus-mux selects, ALU op and done.
//   Sits between the instruction register/run handshake and the datapath
//   (R0..R7, A, G, DIN bus).
//
// PARAMETERS
//   None. Widths are fixed: 9-bit IR, 8 registers, 2-bit step, 2-bit alu_op.
//
// PORTS
//   clk      in   1  system clock; all state updates on the rising edge
//   reset    in   1  synchronous, active-high reset
//   run      in   1  start request; sampled only in T0
//   IR       in   9  instruction: IR[8:6] opcode, IR[5:3] Rx, IR[2:0] Ry
//   step     out  2  current step counter (T0..T3)
//   clear    out  1  step-counter clear = reset | done
//   IRin     out  1  load IR from DIN
//   DINout   out  1  drive DIN onto bus
//   Rout     out  8  one-hot register bus drive; bit i = Ri
//   Gout     out  1  drive G onto bus
//   Rin      out  8  one-hot register load; bit i = Ri
//   Gin      out  1  load G with ALU result
//   Ain      out  1  load A from bus
//   alu_op   out  2  00 NOP, 01 ADD, 10 SUB
//   done     out  1  last step of the current instruction
//
// BEHAVIOUR
//   Opcodes: 000 NOP, 001 MV, 010 ADD, 011 SUB, 100 MVI; 101-111 are
//     decoded as NOP.
//   Step register, next clock edge:
//     - reset -> 0
//     - else if done -> 0
//     - else if step==0 -> 1 when run, else hold 0
//     - else -> step+1
//   Outputs are combinational from step, IR and run.
//   Default for every output is 0; only the listed signals are asserted.
//   While reset=1: clear=1 and all other control outputs are forced to 0.
//   T0: IRin = run.
//   MV  T1: Rout[Ry], Rin[Rx], done.
//   MVI T1: DINout, Rin[Rx], done. Ry is ignored (don't-care).
//   NOP T1: done.
//   ADD T1: Rout[Rx], Ain.
//       T2: Rout[Ry], Gin, alu_op=01.
//       T3: Gout, Rin[Rx], done.
//   SUB: same as ADD, but alu_op=10 in T2.
//   Latency: MV/MVI/NOP take 2 cycles (T0,T1); ADD/SUB take 4 (T0..T3).
//   Rx==Ry is legal; the same one-hot bit is used in Rout and Rin.
//   Rout and Rin are always zero or one-hot.
//   Reset in mid-instruction: step returns to 0 on that edge; no done pulse.
//   Step never wraps past 3 (T3 occurs only for ADD/SUB, where done=1).
//
// CONFIGURATION
//   CU_ILLEGAL_OP_EN defined: adds output port illegal_op (1 bit).
//     It is asserted together with done in T1 for opcodes 101-111.
//   CU_ILLEGAL_OP_EN undefined: no illegal_op port; 101-111 behave as a
//     silent NOP.
//
// TESTING
//   1. reset=1 one cycle -> step=0, clear=1, IRin=0, Rin=0, Rout=0, done=0.
//   2. run=1, IR={001,000,001} (MV R0<-R1) -> T0 IRin=1;
//      T1 Rout=8'h02, Rin=8'h01, done=1, clear=1; then step=0.
//   3. IR={100,010,xxx} (MVI R2) -> T1 DINout=1, Rin=8'h04, done=1.
//   4. IR={010,011,100} (ADD R3+=R4) -> T1 Rout=8'h08, Ain=1;
//      T2 Rout=8'h10, Gin=1, alu_op=01; T3 Gout=1, Rin=8'h08, done=1.
//   5. IR={011,101,110} (SUB R5-=R6) -> T2 alu_op=10, Rout=8'h40;
//      T3 Rin=8'h20, done=1.
//   6. run=0 in T0 -> step holds 0; reset asserted in T2 of an ADD ->
//      step=0 next cycle, no Rin.

Source files
------------

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - step sequencer and instruction decoder for the 9-bit CPU
//
// Purpose: tracks the instruction step T0..T3 and decodes IR = [III YYY XXX]
// (opcode, Rx dest, Ry source) into datapath control strobes.
// Optional feature macro: CU_ILLEGAL_OP_EN (adds the illegal_op output).
//
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  synchronous active-high reset
//   run        in   1  start request, sampled in T0 only
//   IR         in   9  instruction [8:6] opcode, [5:3] Rx, [2:0] Ry
//   step       out  2  current step
//   clear      out  1  step-counter clear (reset | done)
//   IRin       out  1  load IR from DIN
//   DINout     out  1  drive DIN onto the bus
//   Rout       out  8  one-hot register bus drive
//   Gout       out  1  drive G onto the bus
//   Rin        out  8  one-hot register load
//   Gin        out  1  load G with ALU result
//   Ain        out  1  load A from the bus
//   alu_op     out  2  00 NOP, 01 ADD, 10 SUB
//   done       out  1  last step of the instruction
//   illegal_op out  1  (CU_ILLEGAL_OP_EN only) opcode 101-111 seen in T1
module cpu_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [8:0] IR,
  output logic [1:0] step,
  output logic       clear,
  output logic       IRin,
  output logic       DINout,
  output logic [7:0] Rout,
  output logic       Gout,
  output logic [7:0] Rin,
  output logic       Gin,
  output logic       Ain,
  output logic [1:0] alu_op,
`ifdef CU_ILLEGAL_OP_EN
  output logic       illegal_op,
`endif
  output logic       done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MV  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MVI = 3'b100;

  step_e step_q, step_d;

  logic [2:0] opcode;
  logic [7:0] rx_oh, ry_oh;
  logic       is_arith;
  logic       bad_op;

  assign opcode   = IR[8:6];
  assign rx_oh    = 8'd1 << IR[5:3];
  assign ry_oh    = 8'd1 << IR[2:0];
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign bad_op   = opcode[2] && (opcode[1:0] != 2'b00);

  assign step = step_q;

  // Control decode. Reset masks every strobe except clear so that a reset
  // mid-instruction cannot write a register or emit a done pulse.
  always_comb begin
    IRin   = 1'b0;
    DINout = 1'b0;
    Rout   = 8'd0;
    Gout   = 1'b0;
    Rin    = 8'd0;
    Gin    = 1'b0;
    Ain    = 1'b0;
    alu_op = 2'b00;
    done   = 1'b0;
`ifdef CU_ILLEGAL_OP_EN
    illegal_op = 1'b0;
`endif
    if (!reset) begin
      unique case (step_q)
        T0: IRin = run;
        T1: begin
          if (is_arith) begin
            Rout = rx_oh;
            Ain  = 1'b1;
          end else begin
            done = 1'b1;
            if (opcode == OP_MV) begin
              Rout = ry_oh;
              Rin  = rx_oh;
            end else if (opcode == OP_MVI) begin
              DINout = 1'b1;
              Rin    = rx_oh;
            end
`ifdef CU_ILLEGAL_OP_EN
            illegal_op = bad_op;
`endif
          end
        end
        T2: begin
          if (is_arith) begin
            Rout   = ry_oh;
            Gin    = 1'b1;
            alu_op = (opcode == OP_SUB) ? 2'b10 : 2'b01;
          end
        end
        T3: begin
          if (is_arith) begin
            Gout = 1'b1;
            Rin  = rx_oh;
            done = 1'b1;
          end
        end
        default: ;
      endcase
    end
    clear = reset | done;
  end

  // Next step. T3 always returns to T0 so the counter cannot run on even if
  // IR changes under an instruction in progress.
  always_comb begin
    step_d = step_q;
    if (done) begin
      step_d = T0;
    end else begin
      unique case (step_q)
        T0:      step_d = run ? T1 : T0;
        T1:      step_d = T2;
        T2:      step_d = T3;
        T3:      step_d = T0;
        default: step_d = T0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) step_q <= T0;
    else       step_q <= step_d;
  end

  // Opcode constants kept for readability of the decode; NOP needs no term.
  logic unused_ok;
  assign unused_ok = ^{OP_NOP, bad_op};

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed self-checking bench for cpu_control_unit
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [8:0] IR;
  logic [1:0] step;
  logic       clear, IRin, DINout, Gout, Gin, Ain, done;
  logic [7:0] Rout, Rin;
  logic [1:0] alu_op;
`ifdef CU_ILLEGAL_OP_EN
  logic       illegal_op;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .IR     (IR),
    .step   (step),
    .clear  (clear),
    .IRin   (IRin),
    .DINout (DINout),
    .Rout   (Rout),
    .Gout   (Gout),
    .Rin    (Rin),
    .Gin    (Gin),
    .Ain    (Ain),
    .alu_op (alu_op),
`ifdef CU_ILLEGAL_OP_EN
    .illegal_op (illegal_op),
`endif
    .done   (done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, return at the falling edge for stable sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; IR = 9'b001_000_001;
    tick();
    chk("rst_step",  {6'd0, step}, 8'd0);
    chk("rst_clear", {7'd0, clear}, 8'd1);
    chk("rst_irin",  {7'd0, IRin}, 8'd0);
    chk("rst_rin",   Rin, 8'h00);
    chk("rst_rout",  Rout, 8'h00);
    chk("rst_done",  {7'd0, done}, 8'd0);

    // MV R0 <- R1
    reset = 1'b0; run = 1'b1; IR = 9'b001_000_001; #1;
    chk("mv_t0_irin",  {7'd0, IRin}, 8'd1);
    chk("mv_t0_clear", {7'd0, clear}, 8'd0);
    tick();
    chk("mv_t1_step",  {6'd0, step}, 8'd1);
    chk("mv_t1_rout",  Rout, 8'h02);
    chk("mv_t1_rin",   Rin, 8'h01);
    chk("mv_t1_done",  {7'd0, done}, 8'd1);
    chk("mv_t1_clear", {7'd0, clear}, 8'd1);
    chk("mv_t1_irin",  {7'd0, IRin}, 8'd0);
    tick();
    chk("mv_end_step", {6'd0, step}, 8'd0);

    // MVI R2, Ry is don't-care
    IR = 9'b100_010_111; #1;
    chk("mvi_t0_irin", {7'd0, IRin}, 8'd1);
    tick();
    chk("mvi_t1_din",  {7'd0, DINout}, 8'd1);
    chk("mvi_t1_rin",  Rin, 8'h04);
    chk("mvi_t1_rout", Rout, 8'h00);
    chk("mvi_t1_done", {7'd0, done}, 8'd1);
    tick();

    // ADD R3 += R4
    IR = 9'b010_011_100;
    tick();
    chk("add_t1_rout", Rout, 8'h08);
    chk("add_t1_ain",  {7'd0, Ain}, 8'd1);
    chk("add_t1_done", {7'd0, done}, 8'd0);
    chk("add_t1_rin",  Rin, 8'h00);
    tick();
    chk("add_t2_step", {6'd0, step}, 8'd2);
    chk("add_t2_rout", Rout, 8'h10);
    chk("add_t2_gin",  {7'd0, Gin}, 8'd1);
    chk("add_t2_alu",  {6'd0, alu_op}, 8'd1);
    tick();
    chk("add_t3_step", {6'd0, step}, 8'd3);
    chk("add_t3_gout", {7'd0, Gout}, 8'd1);
    chk("add_t3_rin",  Rin, 8'h08);
    chk("add_t3_rout", Rout, 8'h00);
    chk("add_t3_done", {7'd0, done}, 8'd1);
    tick();
    chk("add_end_step", {6'd0, step}, 8'd0);

    // SUB R5 -= R6
    IR = 9'b011_101_110;
    tick();
    chk("sub_t1_rout", Rout, 8'h20);
    tick();
    chk("sub_t2_alu",  {6'd0, alu_op}, 8'd2);
    chk("sub_t2_rout", Rout, 8'h40);
    tick();
    chk("sub_t3_rin",  Rin, 8'h20);
    chk("sub_t3_done", {7'd0, done}, 8'd1);
    tick();

    // MV with Rx == Ry
    IR = 9'b001_011_011;
    tick();
    chk("mvsame_rout", Rout, 8'h08);
    chk("mvsame_rin",  Rin, 8'h08);
    tick();

    // Unused opcode behaves as NOP
    IR = 9'b111_010_001;
    tick();
    chk("bad_t1_done", {7'd0, done}, 8'd1);
    chk("bad_t1_rin",  Rin, 8'h00);
    chk("bad_t1_rout", Rout, 8'h00);
    chk("bad_t1_alu",  {6'd0, alu_op}, 8'd0);
`ifdef CU_ILLEGAL_OP_EN
    chk("bad_t1_illegal", {7'd0, illegal_op}, 8'd1);
`endif
    tick();

    // run low holds T0
    run = 1'b0; #1;
    chk("idle_irin", {7'd0, IRin}, 8'd0);
    tick();
    chk("idle_step1", {6'd0, step}, 8'd0);
    tick();
    chk("idle_step2", {6'd0, step}, 8'd0);
    chk("idle_done",  {7'd0, done}, 8'd0);

    // Reset in T2 of an ADD
    run = 1'b1; IR = 9'b010_001_010;
    tick();
    tick();
    chk("rmid_step_t2", {6'd0, step}, 8'd2);
    reset = 1'b1; #1;
    chk("rmid_clear", {7'd0, clear}, 8'd1);
    chk("rmid_rout",  Rout, 8'h00);
    chk("rmid_gin",   {7'd0, Gin}, 8'd0);
    chk("rmid_alu",   {6'd0, alu_op}, 8'd0);
    tick();
    reset = 1'b0; run = 1'b0; #1;
    chk("rmid_step_after", {6'd0, step}, 8'd0);
    chk("rmid_rin_after",  Rin, 8'h00);
    chk("rmid_done_after", {7'd0, done}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
